// File: rtl/test_stub_bist_pkg.sv
// test_stub_bist_pkg: FSM states, ctl bit indices, CTU serial order and CSR field offsets for test_stub_mbist_n
package test_stub_bist_pkg;
  typedef enum logic [1:0] {S_IDLE, S_SETUP, S_RUN, S_DONE} state_t;
  localparam int CTL_W = 7;
  localparam int CTL_START = 0;
  localparam int CTL_DATA_MODE = 1;
  localparam int CTL_LOOP_ON_ADDR = 2;
  localparam int CTL_LOOP = 3;
  localparam int CTL_STOP_ON_FAIL = 4;
  localparam int CTL_STOP_ON_NEXT_FAIL = 5;
  localparam int CTL_BISI = 6;
  localparam logic [20:0] SER_ORDER = {3'd5, 3'd4, 3'd3, 3'd2, 3'd1, 3'd6, 3'd0};
  function automatic logic [2:0] ser_bit(input logic [2:0] i);
    return SER_ORDER[(6 - int'(i)) * 3 +: 3];
  endfunction
  function automatic int csr_fail_lsb();
    return CTL_W;
  endfunction
  function automatic int csr_done_bit(input int n);
    return CTL_W + n;
  endfunction
  function automatic int csr_timeout_bit(input int n);
    return CTL_W + n + 1;
  endfunction
endpackage

// File: rtl/test_stub_mbist_n_if.sv
// test_stub_mbist_n_if: CSR bus (write data/strobe in, status/counters out); master = CSR host, slave = stub
interface test_stub_mbist_n_if #(
  parameter int NUM_ARRAYS = 3,
  parameter int FAIL_CNT_W = 4
);
  logic [6:0] bist_ctl_reg_in;
  logic bist_ctl_reg_wr_en;
  logic [NUM_ARRAYS+8:0] bist_ctl_reg_out;
  logic [NUM_ARRAYS*FAIL_CNT_W-1:0] fail_cnt_out;
  modport master (output bist_ctl_reg_in, bist_ctl_reg_wr_en, input bist_ctl_reg_out, fail_cnt_out);
  modport slave (input bist_ctl_reg_in, bist_ctl_reg_wr_en, output bist_ctl_reg_out, fail_cnt_out);
endinterface

// File: rtl/mbist_fail_counter.sv
// mbist_fail_counter: per-array sticky fail flag and saturating fail counter; ports rclk, cluster_grst_l, clear, enable, err -> sticky, cnt
module mbist_fail_counter #(
  parameter int FAIL_CNT_W = 4
) (
  input  logic rclk,
  input  logic cluster_grst_l,
  input  logic clear,
  input  logic enable,
  input  logic err,
  output logic sticky,
  output logic [FAIL_CNT_W-1:0] cnt
);
  always_ff @(posedge rclk) begin
    if (!cluster_grst_l || clear) begin
      sticky <= 1'b0;
      cnt <= '0;
    end else if (enable && err) begin
      sticky <= 1'b1;
      cnt <= &cnt ? cnt : cnt + FAIL_CNT_W'(1);
    end
  end
endmodule

// File: rtl/test_stub_mbist_n.sv
// test_stub_mbist_n: MBIST stub with run FSM, per-array fail counters and watchdog; ports rclk, cluster_grst_l, ctu serial enable, timeout_limit, engine done/err, mbist_ctl, CTU done/fail, csr bus
module test_stub_mbist_n
  import test_stub_bist_pkg::*;
#(
  parameter int NUM_ARRAYS = 3,
  parameter int FAIL_CNT_W = 4,
  parameter int TIMEOUT_W = 16
) (
  input  logic rclk,
  input  logic cluster_grst_l,
  input  logic ctu_tst_mbist_enable,
  input  logic [TIMEOUT_W-1:0] timeout_limit,
  input  logic mbist_done,
  input  logic [NUM_ARRAYS-1:0] mbist_err,
  output logic [6:0] mbist_ctl,
  output logic tst_ctu_mbist_done,
  output logic tst_ctu_mbist_fail,
  test_stub_mbist_n_if.slave csr
);
  state_t state;
  logic d1, d2, done, timeout, fail_q;
  logic [2:0] bit_cnt;
  logic [6:0] ctl;
  logic [TIMEOUT_W-1:0] wd;
  logic [NUM_ARRAYS-1:0] sticky;
  logic [NUM_ARRAYS*FAIL_CNT_W-1:0] cnt_flat;
  logic idle_or_done, setup_edge, wd_hit, clear, run;
  always_comb begin
    idle_or_done = state == S_IDLE || state == S_DONE;
    run = state == S_RUN;
    setup_edge = d1 & ~d2;
    wd_hit = timeout_limit != '0 && wd == timeout_limit - TIMEOUT_W'(1);
    clear = idle_or_done && (setup_edge || (csr.bist_ctl_reg_wr_en && csr.bist_ctl_reg_in[CTL_START]));
  end
  always_ff @(posedge rclk) begin
    if (!cluster_grst_l) begin
      state <= S_IDLE;
      d1 <= 1'b0;
      d2 <= 1'b0;
      bit_cnt <= '0;
      ctl <= '0;
      done <= 1'b0;
      timeout <= 1'b0;
      wd <= '0;
      fail_q <= 1'b0;
    end else begin
      d1 <= ctu_tst_mbist_enable;
      d2 <= d1;
      fail_q <= |sticky | timeout;
      case (state)
        S_IDLE, S_DONE: begin
          if (setup_edge) begin
            state <= S_SETUP;
            bit_cnt <= '0;
            done <= 1'b0;
            timeout <= 1'b0;
          end else if (csr.bist_ctl_reg_wr_en) begin
            ctl <= csr.bist_ctl_reg_in;
            if (csr.bist_ctl_reg_in[CTL_START]) begin
              state <= S_RUN;
              done <= 1'b0;
              timeout <= 1'b0;
              wd <= '0;
            end
          end
        end
        S_SETUP: begin
          ctl[ser_bit(bit_cnt)] <= d2;
          bit_cnt <= bit_cnt + 3'd1;
          wd <= '0;
          if (bit_cnt == 3'd6) state <= d2 ? S_RUN : S_IDLE;
        end
        S_RUN: begin
          wd <= wd + TIMEOUT_W'(1);
          if (mbist_done || wd_hit) begin
            state <= S_DONE;
            done <= 1'b1;
            timeout <= !mbist_done;
            ctl[CTL_START] <= 1'b0;
          end else if (csr.bist_ctl_reg_wr_en && !csr.bist_ctl_reg_in[CTL_START]) begin
            state <= S_IDLE;
            ctl[CTL_START] <= 1'b0;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end
  for (genvar i = 0; i < NUM_ARRAYS; i++) begin : g_cnt
    mbist_fail_counter #(.FAIL_CNT_W(FAIL_CNT_W)) u_cnt (
      .rclk(rclk),
      .cluster_grst_l(cluster_grst_l),
      .clear(clear),
      .enable(run),
      .err(mbist_err[i]),
      .sticky(sticky[i]),
      .cnt(cnt_flat[i*FAIL_CNT_W +: FAIL_CNT_W])
    );
  end
  always_comb begin
    csr.bist_ctl_reg_out = '0;
    csr.bist_ctl_reg_out[CTL_W-1:0] = ctl;
    csr.bist_ctl_reg_out[csr_fail_lsb() +: NUM_ARRAYS] = sticky;
    csr.bist_ctl_reg_out[csr_done_bit(NUM_ARRAYS)] = done;
    csr.bist_ctl_reg_out[csr_timeout_bit(NUM_ARRAYS)] = timeout;
  end
  assign csr.fail_cnt_out = cnt_flat;
  assign mbist_ctl = ctl;
  assign tst_ctu_mbist_done = done;
  assign tst_ctu_mbist_fail = fail_q;
endmodule

// File: tb/tb_test_stub_mbist_n.sv
// tb_test_stub_mbist_n: directed table and sequence checks of test_stub_mbist_n with 4 arrays and 2-bit counters
module tb_test_stub_mbist_n;
  localparam int NA = 4;
  localparam int FW = 2;
  localparam int TW = 16;
  typedef struct {
    logic [6:0] wd;
    logic we;
    logic dn;
    logic [3:0] err;
    logic [6:0] ctl;
    logic done;
    logic [3:0] sticky;
    logic [7:0] cnt;
    logic fail;
  } vec_t;
  logic rclk = 1'b0;
  logic rst_l = 1'b0;
  logic enable = 1'b0;
  logic mdone = 1'b0;
  logic [NA-1:0] err = '0;
  logic [TW-1:0] tlim = '0;
  logic [6:0] mbist_ctl;
  logic tdone, tfail;
  int checks = 0;
  int errors = 0;
  vec_t tbl [14];
  always #5 rclk = ~rclk;
  test_stub_mbist_n_if #(.NUM_ARRAYS(NA), .FAIL_CNT_W(FW)) csr_if ();
  test_stub_mbist_n #(.NUM_ARRAYS(NA), .FAIL_CNT_W(FW), .TIMEOUT_W(TW)) dut (
    .rclk(rclk),
    .cluster_grst_l(rst_l),
    .ctu_tst_mbist_enable(enable),
    .timeout_limit(tlim),
    .mbist_done(mdone),
    .mbist_err(err),
    .mbist_ctl(mbist_ctl),
    .tst_ctu_mbist_done(tdone),
    .tst_ctu_mbist_fail(tfail),
    .csr(csr_if)
  );
  task automatic step;
    @(posedge rclk);
    @(negedge rclk);
  endtask
  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s got %0h want %0h", n, a, e);
    end
  endtask
  task automatic csr_wr(input logic [6:0] d);
    csr_if.bist_ctl_reg_in = d;
    csr_if.bist_ctl_reg_wr_en = 1'b1;
    step;
    csr_if.bist_ctl_reg_wr_en = 1'b0;
  endtask
  task automatic serial(input logic [6:0] v, input logic collide, input logic [6:0] prev);
    logic [6:0] b;
    b = {v[5], v[4], v[3], v[2], v[1], v[6], v[0]};
    for (int i = 0; i < 7; i++) begin
      enable = b[6-i];
      if (i == 1 && collide) begin
        csr_if.bist_ctl_reg_in = 7'h01;
        csr_if.bist_ctl_reg_wr_en = 1'b1;
      end
      step;
      csr_if.bist_ctl_reg_wr_en = 1'b0;
      if (i == 1 && collide) chk("collide_ctl", 32'(mbist_ctl), 32'(prev));
    end
    enable = 1'b0;
    step;
    chk("ser_k7_start", 32'(mbist_ctl[0]), 32'd0);
    step;
    chk("ser_k8_ctl", 32'(mbist_ctl), 32'(v));
    chk("ser_k8_done", 32'(tdone), 32'd0);
  endtask
  initial begin
    csr_if.bist_ctl_reg_in = '0;
    csr_if.bist_ctl_reg_wr_en = 1'b0;
    tbl[0]  = '{7'h01, 1'b1, 1'b0, 4'h0, 7'h01, 1'b0, 4'h0, 8'h00, 1'b0};
    tbl[1]  = '{7'h00, 1'b0, 1'b0, 4'h4, 7'h01, 1'b0, 4'h4, 8'h10, 1'b0};
    tbl[2]  = '{7'h00, 1'b0, 1'b0, 4'h4, 7'h01, 1'b0, 4'h4, 8'h20, 1'b1};
    tbl[3]  = '{7'h00, 1'b0, 1'b0, 4'h4, 7'h01, 1'b0, 4'h4, 8'h30, 1'b1};
    tbl[4]  = '{7'h00, 1'b0, 1'b0, 4'h4, 7'h01, 1'b0, 4'h4, 8'h30, 1'b1};
    tbl[5]  = '{7'h00, 1'b0, 1'b0, 4'h4, 7'h01, 1'b0, 4'h4, 8'h30, 1'b1};
    tbl[6]  = '{7'h00, 1'b0, 1'b1, 4'h1, 7'h00, 1'b1, 4'h5, 8'h31, 1'b1};
    tbl[7]  = '{7'h00, 1'b0, 1'b0, 4'h0, 7'h00, 1'b1, 4'h5, 8'h31, 1'b1};
    tbl[8]  = '{7'h0A, 1'b1, 1'b0, 4'h0, 7'h0A, 1'b1, 4'h5, 8'h31, 1'b1};
    tbl[9]  = '{7'h05, 1'b1, 1'b0, 4'h0, 7'h05, 1'b0, 4'h0, 8'h00, 1'b1};
    tbl[10] = '{7'h00, 1'b0, 1'b0, 4'h8, 7'h05, 1'b0, 4'h8, 8'h40, 1'b0};
    tbl[11] = '{7'h7E, 1'b1, 1'b0, 4'h0, 7'h04, 1'b0, 4'h8, 8'h40, 1'b1};
    tbl[12] = '{7'h00, 1'b0, 1'b0, 4'h2, 7'h04, 1'b0, 4'h8, 8'h40, 1'b1};
    tbl[13] = '{7'h7E, 1'b1, 1'b0, 4'h0, 7'h7E, 1'b0, 4'h8, 8'h40, 1'b1};
    @(negedge rclk);
    step;
    step;
    chk("rst_ctl", 32'(mbist_ctl), 32'd0);
    chk("rst_done", 32'(tdone), 32'd0);
    chk("rst_fail", 32'(tfail), 32'd0);
    chk("rst_reg", 32'(csr_if.bist_ctl_reg_out), 32'd0);
    chk("rst_cnt", 32'(csr_if.fail_cnt_out), 32'd0);
    rst_l = 1'b1;
    step;
    csr_wr(7'h01);
    for (int i = 0; i < 20; i++) begin
      chk($sformatf("csr_run%0d", i), 32'({mbist_ctl[0], tdone}), 32'b10);
      if (i == 19) mdone = 1'b1;
      step;
    end
    mdone = 1'b0;
    chk("csr_done", 32'(tdone), 32'd1);
    chk("csr_ctl", 32'(mbist_ctl), 32'd0);
    chk("csr_fail", 32'(tfail), 32'd0);
    for (int i = 0; i < 14; i++) begin
      csr_if.bist_ctl_reg_in = tbl[i].wd;
      csr_if.bist_ctl_reg_wr_en = tbl[i].we;
      mdone = tbl[i].dn;
      err = tbl[i].err;
      step;
      csr_if.bist_ctl_reg_wr_en = 1'b0;
      mdone = 1'b0;
      err = '0;
      chk($sformatf("vec%0d_ctl", i), 32'(mbist_ctl), 32'(tbl[i].ctl));
      chk($sformatf("vec%0d_reg", i), 32'(csr_if.bist_ctl_reg_out), 32'({1'b0, tbl[i].done, tbl[i].sticky, tbl[i].ctl}));
      chk($sformatf("vec%0d_cnt", i), 32'(csr_if.fail_cnt_out), 32'(tbl[i].cnt));
      chk($sformatf("vec%0d_done", i), 32'(tdone), 32'(tbl[i].done));
      chk($sformatf("vec%0d_fail", i), 32'(tfail), 32'(tbl[i].fail));
    end
    serial(7'b1110011, 1'b0, 7'h7E);
    chk("ser1_sticky", 32'(csr_if.bist_ctl_reg_out[10:7]), 32'd0);
    mdone = 1'b1;
    step;
    mdone = 1'b0;
    chk("ser1_done", 32'(tdone), 32'd1);
    chk("ser1_ctl", 32'(mbist_ctl), 32'(7'b1110010));
    chk("ser1_fail", 32'(tfail), 32'd0);
    serial(7'b0100110, 1'b1, 7'b1110010);
    mdone = 1'b1;
    step;
    mdone = 1'b0;
    chk("ser2_idle_done", 32'(tdone), 32'd0);
    chk("ser2_ctl", 32'(mbist_ctl), 32'(7'b0100110));
    tlim = 16'd10;
    csr_wr(7'h01);
    for (int i = 0; i < 10; i++) begin
      chk($sformatf("wd_run%0d", i), 32'({mbist_ctl[0], tdone}), 32'b10);
      step;
    end
    chk("wd_done", 32'(tdone), 32'd1);
    chk("wd_timeout", 32'(csr_if.bist_ctl_reg_out[12]), 32'd1);
    chk("wd_ctl0", 32'(mbist_ctl[0]), 32'd0);
    chk("wd_fail_lag", 32'(tfail), 32'd0);
    step;
    chk("wd_fail", 32'(tfail), 32'd1);
    csr_wr(7'h01);
    for (int i = 0; i < 10; i++) begin
      chk($sformatf("wd2_run%0d", i), 32'({mbist_ctl[0], tdone}), 32'b10);
      if (i == 9) mdone = 1'b1;
      step;
    end
    mdone = 1'b0;
    chk("wd2_done", 32'(tdone), 32'd1);
    chk("wd2_timeout", 32'(csr_if.bist_ctl_reg_out[12]), 32'd0);
    step;
    chk("wd2_fail", 32'(tfail), 32'd0);
    tlim = '0;
    csr_wr(7'h01);
    err = 4'hF;
    step;
    step;
    chk("mid_cnt", 32'(csr_if.fail_cnt_out), 32'hAA);
    rst_l = 1'b0;
    step;
    rst_l = 1'b1;
    chk("mrst_ctl", 32'(mbist_ctl), 32'd0);
    chk("mrst_done", 32'(tdone), 32'd0);
    chk("mrst_fail", 32'(tfail), 32'd0);
    chk("mrst_reg", 32'(csr_if.bist_ctl_reg_out), 32'd0);
    chk("mrst_cnt", 32'(csr_if.fail_cnt_out), 32'd0);
    step;
    err = '0;
    chk("mrst_idle_cnt", 32'(csr_if.fail_cnt_out), 32'd0);
    chk("mrst_idle_reg", 32'(csr_if.bist_ctl_reg_out), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
